// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// ifu : hxd32 instruction fetch; holds the PC and picks the next fetch address
//       from a partial pre-decode (JAL, static backward-taken branch, PC+4).
// Rev 1.0
// ============================================================================
module ifu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_wr_en_i,
  input  logic [XLEN-1:0] iram_rd_data_i,
  output logic [XLEN-1:0] iram_rd_addr_o
);

  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [31:0]     w_inst;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_next;

  assign w_inst = iram_rd_data_i[31:0];

  assign w_imm_j = {{(XLEN-20){w_inst[31]}}, w_inst[19:12], w_inst[20],
                    w_inst[30:21], 1'b0};
  assign w_imm_b = {{(XLEN-12){w_inst[31]}}, w_inst[7], w_inst[30:25],
                    w_inst[11:8], 1'b0};

  // Backward branches (negative immediate) are predicted taken; JALR and
  // mispredicts are fixed up downstream, so everything else falls through.
  always_comb begin
    w_next = pc_q + XLEN'(4);
    if (w_inst[6:0] == c_OPC_JAL) begin
      w_next = pc_q + w_imm_j;
    end else if ((w_inst[6:0] == c_OPC_BRANCH) && w_inst[31]) begin
      w_next = pc_q + w_imm_b;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_wr_en_i) begin
      pc_d = w_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign iram_rd_addr_o = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// Self-checking bench for ifu: directed scenarios plus a randomized long run
// compared against an arithmetic next-PC model.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] data;
  logic [31:0] addr;
  logic [31:0] model_pc;
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  ifu #(.XLEN(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pc_wr_en_i     (we),
    .iram_rd_data_i (data),
    .iram_rd_addr_o (addr)
  );

  // Next PC from the instruction rules, built by weighting immediate fields.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] inst);
    logic [31:0] imm;
    if (inst[6:0] == 7'b1101111) begin
      imm = 32'(inst[19:12]) * 4096 + 32'(inst[20]) * 2048 + 32'(inst[30:21]) * 2;
      if (inst[31]) imm = imm - 32'(1 << 20);
      return pc + imm;
    end
    if (inst[6:0] == 7'b1100011 && inst[31]) begin
      imm = 32'(inst[7]) * 2048 + 32'(inst[30:25]) * 32 + 32'(inst[11:8]) * 2 - 32'd4096;
      return pc + imm;
    end
    return pc + 32'd4;
  endfunction

  task automatic step(input logic [31:0] d, input logic w, input logic r);
    data = d;
    we   = w;
    rst  = r;
    @(posedge clk);
    if (r) model_pc = 32'd0;
    else if (w) model_pc = ref_next(model_pc, d);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(NOP, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step($urandom, 1'($urandom), 1'b1);
      n_tests++;
      if (addr !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold: addr=%h expected=%h", addr, 32'h0);
      end
    end
    nops(5);
    step(NOP, 1'b1, 1'b1);
    n_tests++;
    if (addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: addr=%h expected=%h", addr, 32'h0);
    end
  endtask

  task automatic test_sequential();
    step(NOP, 1'b1, 1'b1);
    n_tests++;
    if (addr !== 32'h0) begin
      n_fail++;
      $display("FAIL seq_0: addr=%h expected=%h", addr, 32'h0);
    end
    nops(1);
    n_tests++;
    if (addr !== 32'h4) begin
      n_fail++;
      $display("FAIL seq_4: addr=%h expected=%h", addr, 32'h4);
    end
    nops(1);
    n_tests++;
    if (addr !== 32'h8) begin
      n_fail++;
      $display("FAIL seq_8: addr=%h expected=%h", addr, 32'h8);
    end
    for (int i = 0; i < 4; i++) begin
      step($urandom, 1'b0, 1'b0);
      n_tests++;
      if (addr !== 32'h8) begin
        n_fail++;
        $display("FAIL stall_hold: cycle=%0d addr=%h expected=%h", i, addr, 32'h8);
      end
    end
    nops(1);
    n_tests++;
    if (addr !== 32'hC) begin
      n_fail++;
      $display("FAIL seq_c: addr=%h expected=%h", addr, 32'hC);
    end
  endtask

  task automatic test_jal();
    step(NOP, 1'b1, 1'b1);
    nops(1);
    step(32'h0100_026F, 1'b1, 1'b0);
    n_tests++;
    if (addr !== 32'h14) begin
      n_fail++;
      $display("FAIL jal_4: addr=%h expected=%h", addr, 32'h14);
    end
    step(NOP, 1'b1, 1'b1);
    nops(4);
    step(32'h0100_006F, 1'b1, 1'b0);
    n_tests++;
    if (addr !== 32'h20) begin
      n_fail++;
      $display("FAIL jal_10: addr=%h expected=%h", addr, 32'h20);
    end
  endtask

  task automatic test_branch();
    step(NOP, 1'b1, 1'b1);
    nops(7);
    step(32'h0041_1263, 1'b1, 1'b0);
    n_tests++;
    if (addr !== 32'h20) begin
      n_fail++;
      $display("FAIL bne_fwd: addr=%h expected=%h", addr, 32'h20);
    end
    step(32'hFE00_0CE3, 1'b1, 1'b0);
    n_tests++;
    if (addr !== 32'h18) begin
      n_fail++;
      $display("FAIL beq_back: addr=%h expected=%h", addr, 32'h18);
    end
    step(NOP, 1'b1, 1'b1);
    nops(8);
    step(32'h0003_02E7, 1'b1, 1'b0);
    n_tests++;
    if (addr !== 32'h24) begin
      n_fail++;
      $display("FAIL jalr_seq: addr=%h expected=%h", addr, 32'h24);
    end
    step(NOP, 1'b1, 1'b1);
    nops(2);
    step(32'h0000_0117, 1'b1, 1'b0);
    n_tests++;
    if (addr !== 32'hC) begin
      n_fail++;
      $display("FAIL auipc_seq: addr=%h expected=%h", addr, 32'hC);
    end
  endtask

  task automatic test_wrap();
    step(NOP, 1'b1, 1'b1);
    step(32'hFE00_0CE3, 1'b1, 1'b0);
    n_tests++;
    if (addr !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL wrap_back: addr=%h expected=%h", addr, 32'hFFFF_FFF8);
    end
    nops(1);
    n_tests++;
    if (addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_fc: addr=%h expected=%h", addr, 32'hFFFF_FFFC);
    end
    nops(1);
    n_tests++;
    if (addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_zero: addr=%h expected=%h", addr, 32'h0);
    end
  endtask

  task automatic test_long_run();
    logic [31:0] prog [16];
    for (int i = 0; i < 16; i++) begin
      case (i % 6)
        0: prog[i] = NOP;
        1: prog[i] = {$urandom_range(0, 32'h01FF_FFFF), 7'b1101111};
        2: prog[i] = {1'b1, 24'($urandom), 7'b1100011};
        3: prog[i] = {1'b0, 24'($urandom), 7'b1100011};
        4: prog[i] = {$urandom_range(0, 32'h01FF_FFFF), 7'b1100111};
        default: prog[i] = $urandom;
      endcase
    end
    step(NOP, 1'b1, 1'b1);
    for (int c = 0; c < 1000; c++) begin
      step(prog[c % 16], ($urandom % 4) != 0, 1'b0);
      n_tests++;
      if (addr !== model_pc) begin
        n_fail++;
        $display("FAIL long_run: cycle=%0d addr=%h expected=%h", c, addr, model_pc);
      end
    end
    step(prog[0], 1'b1, 1'b1);
    n_tests++;
    if (addr !== 32'h0) begin
      n_fail++;
      $display("FAIL long_reset: addr=%h expected=%h", addr, 32'h0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    we       = 1'b0;
    data     = NOP;
    model_pc = 32'd0;
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_wrap();
    test_long_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit for the hxd32 RV32I core. It holds the program counter (PC) and drives it as the instruction RAM read address. It partially pre-decodes the returned instruction word to choose the next PC: sequential, JAL target, or statically-predicted backward branch. It sits between the instruction RAM and the decode stage, and its PC advance is gated by an external write enable from pipeline control.

## Interface
- XLEN, default 32: PC and data width; immediates are sign-extended to XLEN.

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- pc_wr_en_i  input  1  PC update enable; 0 holds the PC.
- iram_rd_data_i  input  XLEN  instruction word read from IRAM at the current iram_rd_addr_o; treated as combinational (same cycle).
- iram_rd_addr_o  output  XLEN  current PC, driven directly from the PC register.

## Operation
- State: a single XLEN-bit PC register. iram_rd_addr_o = PC at all times, with no combinational path from inputs.
- Next-PC selection from the instruction word `inst = iram_rd_data_i`, using opcode `inst[6:0]`:
  - JAL (7'b1101111): next = PC + imm_j.
    - imm_j = sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - BRANCH (7'b1100011), when inst[31]=1 (backward, static predict taken): next = PC + imm_b.
    - imm_b = sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - BRANCH with inst[31]=0 (forward, predict not-taken): next = PC + 4.
  - JALR, all other opcodes, and illegal or unknown encodings: next = PC + 4.
    - JALR targets and branch mispredictions are resolved downstream; this block has no redirect input.
- Arithmetic: all additions are modulo 2^XLEN; wrap-around is silent.
- Alignment: no alignment check and no exception. Targets are used exactly as computed, so bit 1 may be set by an immediate.
- Funct3 fields, register fields and rd are ignored; the target depends only on the opcode and the immediate bits.

## Timing
- Reset: rst_i=1 at a rising edge sets PC = 0 and hence iram_rd_addr_o = 0.
  - Reset has priority over pc_wr_en_i.
  - Asserting reset mid-operation takes effect at the next edge; the fetch in flight is discarded.
- Normal operation, rst_i=0, pc_wr_en_i=1: at each rising edge PC <= next, where next is computed from the iram_rd_data_i present during that cycle.
  - Latency is one cycle from an address being presented to the following address.
  - Throughput is one fetch per cycle.
- Stall, pc_wr_en_i=0: the PC holds and iram_rd_data_i is ignored.
- After reset deassertion, the first update uses the instruction read at address 0.
- Before the first clock edge the PC value is undefined; the bench must apply reset first.

## Test plan
- Reset: hold rst_i=1 for 2 edges with any data → iram_rd_addr_o = 0x00000000. Then assert rst_i=1 mid-run with pc_wr_en_i=1 → address returns to 0 at the next edge.
- Sequential fetch: iram_rd_data_i = 0x00000013 (nop), pc_wr_en_i=1 from PC=0 → addresses 0x0, 0x4, 0x8, 0xC on successive cycles. Setting pc_wr_en_i=0 at PC=0x8 → address holds at 0x8 for every stalled cycle.
- JAL: at PC=0x4, data 0x0100026F (jal x4,16) → next address 0x14. At PC=0x10, data 0x0100006F → next address 0x20.
- Branches:
  - At PC=0x1C, data 0x00411263 (bne, +4, forward) → 0x20.
  - At PC=0x20, data 0xFE000CE3 (beq x0,x0,-8) → 0x18.
  - At PC=0x20, data 0x000302E7 (jalr) → 0x24.
  - At PC=0x8, data 0x00000117 (auipc) → 0xC.
- Wrap-around: PC=0xFFFFFFFC with nop → 0x00000000. PC=0x0 with 0xFE000CE3 → 0xFFFFFFF8.
- Long run: a cycling instruction sequence for about 1000 cycles, then reset → address equals a reference-model PC every cycle, and 0 after reset.
